// File: rtl/astar_seq_ctrl.sv
// astar_seq_ctrl
// Sequencing controller for a grid A* search datapath. It steps the datapath
// through INIT -> (UPDATE -> MOVE)* -> BACKTRACE, counts MOVE->UPDATE
// iterations, bounds the search at MAX_STEPS, and reports the outcome as a
// registered one-cycle pulse on the first IDLE cycle after the search ends.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   start, abort                request a search / cancel an active search
//   goal_row, goal_col          goal cell, latched when start is accepted
//   pointer_row, pointer_col    cell currently expanded by the datapath
//   init_done .. queue_empty    datapath status strobes
//   state                       current state code (IDLE=0 .. BACKTRACE=4)
//   init_en .. backtrace_en     phase enables, decoded from state
//   busy                        high outside IDLE
//   path_ready .. cfg_err       one-cycle result pulses
//   step_count                  completed iterations of current/last search
module astar_seq_ctrl #(
    parameter int unsigned ROWS      = 10,
    parameter int unsigned COLS      = 10,
    parameter int unsigned MAX_STEPS = 255,
    parameter int unsigned CW        = 4,
    parameter int unsigned SW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] goal_row,
    input  logic [CW-1:0] goal_col,
    input  logic [CW-1:0] pointer_row,
    input  logic [CW-1:0] pointer_col,
    input  logic          init_done,
    input  logic          update_done,
    input  logic          move_done,
    input  logic          backtrace_done,
    input  logic          queue_empty,
    output logic [2:0]    state,
    output logic          init_en,
    output logic          update_en,
    output logic          move_en,
    output logic          backtrace_en,
    output logic          busy,
    output logic          path_ready,
    output logic          no_path,
    output logic          timeout,
    output logic          aborted,
    output logic          cfg_err,
    output logic [SW-1:0] step_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_UPDATE    = 3'd2,
        S_MOVE      = 3'd3,
        S_BACKTRACE = 3'd4
    } state_e;

    // One extra bit so ROWS/COLS = 2**CW still compare correctly.
    localparam logic [CW:0]   ROWS_L    = (CW+1)'(ROWS);
    localparam logic [CW:0]   COLS_L    = (CW+1)'(COLS);
    localparam logic [SW-1:0] LAST_STEP = SW'(MAX_STEPS - 1);
    localparam logic [SW-1:0] STEP_MAX  = SW'(MAX_STEPS);

    state_e        state_q, state_d;
    logic [CW-1:0] goal_row_q, goal_row_d;
    logic [CW-1:0] goal_col_q, goal_col_d;
    logic [SW-1:0] step_q, step_d;
    logic          path_ready_q, path_ready_d;
    logic          no_path_q, no_path_d;
    logic          timeout_q, timeout_d;
    logic          aborted_q, aborted_d;
    logic          cfg_err_q, cfg_err_d;

    logic goal_ok;
    logic at_goal;

    assign goal_ok = ({1'b0, goal_row} < ROWS_L) && ({1'b0, goal_col} < COLS_L);
    assign at_goal = (pointer_row == goal_row_q) && (pointer_col == goal_col_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            goal_row_q   <= '0;
            goal_col_q   <= '0;
            step_q       <= '0;
            path_ready_q <= 1'b0;
            no_path_q    <= 1'b0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            goal_row_q   <= goal_row_d;
            goal_col_q   <= goal_col_d;
            step_q       <= step_d;
            path_ready_q <= path_ready_d;
            no_path_q    <= no_path_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        goal_row_d   = goal_row_q;
        goal_col_d   = goal_col_q;
        step_d       = step_q;
        path_ready_d = 1'b0;
        no_path_d    = 1'b0;
        timeout_d    = 1'b0;
        aborted_d    = 1'b0;
        cfg_err_d    = 1'b0;

        if (state_q != S_IDLE && abort) begin
            // Abort outranks every status strobe in the same cycle.
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (goal_ok) begin
                            goal_row_d = goal_row;
                            goal_col_d = goal_col;
                            step_d     = '0;
                            state_d    = S_INIT;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    if (init_done) state_d = S_UPDATE;
                end
                S_UPDATE: begin
                    if (update_done) state_d = S_MOVE;
                end
                S_MOVE: begin
                    if (at_goal) begin
                        state_d = S_BACKTRACE;
                    end else if (queue_empty) begin
                        state_d   = S_IDLE;
                        no_path_d = 1'b1;
                    end else if (move_done) begin
                        if (step_q == LAST_STEP) begin
                            // Final iteration: count saturates at MAX_STEPS.
                            step_d    = STEP_MAX;
                            state_d   = S_IDLE;
                            timeout_d = 1'b1;
                        end else begin
                            step_d  = step_q + SW'(1);
                            state_d = S_UPDATE;
                        end
                    end
                end
                S_BACKTRACE: begin
                    if (backtrace_done) begin
                        state_d      = S_IDLE;
                        path_ready_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign state        = state_q;
    assign init_en      = (state_q == S_INIT);
    assign update_en    = (state_q == S_UPDATE);
    assign move_en      = (state_q == S_MOVE);
    assign backtrace_en = (state_q == S_BACKTRACE);
    assign busy         = (state_q != S_IDLE);
    assign path_ready   = path_ready_q;
    assign no_path      = no_path_q;
    assign timeout      = timeout_q;
    assign aborted      = aborted_q;
    assign cfg_err      = cfg_err_q;
    assign step_count   = step_q;

endmodule

// File: tb/tb_astar_seq_ctrl.sv
// Self-checking bench for astar_seq_ctrl. The driver walks each search at the
// level of "phases and iterations", pushing the expected phase of every cycle
// and the expected result pulse of every search into queues; a negedge monitor
// pops and compares whatever the DUT presents.
module tb_astar_seq_ctrl;

    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int MAXS = 4;

    localparam int P_IDLE = 0, P_INIT = 1, P_UPD = 2, P_MOVE = 3, P_BT = 4;
    localparam int K_FOUND = 0, K_EMPTY = 1, K_RST = 2;

    localparam logic [4:0] R_PATH = 5'b10000;
    localparam logic [4:0] R_NOP  = 5'b01000;
    localparam logic [4:0] R_TMO  = 5'b00100;
    localparam logic [4:0] R_ABT  = 5'b00010;
    localparam logic [4:0] R_CFG  = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0;
    logic [3:0] goal_row = '0, goal_col = '0, pointer_row = '0, pointer_col = '0;
    logic init_done = 1'b0, update_done = 1'b0, move_done = 1'b0;
    logic backtrace_done = 1'b0, queue_empty = 1'b0;
    logic [2:0]  state;
    logic        init_en, update_en, move_en, backtrace_en, busy;
    logic        path_ready, no_path, timeout, aborted, cfg_err;
    logic [15:0] step_count;

    astar_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_STEPS(MAXS), .CW(4), .SW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .goal_row(goal_row), .goal_col(goal_col),
        .pointer_row(pointer_row), .pointer_col(pointer_col),
        .init_done(init_done), .update_done(update_done), .move_done(move_done),
        .backtrace_done(backtrace_done), .queue_empty(queue_empty),
        .state(state), .init_en(init_en), .update_en(update_en), .move_en(move_en),
        .backtrace_en(backtrace_en), .busy(busy),
        .path_ready(path_ready), .no_path(no_path), .timeout(timeout),
        .aborted(aborted), .cfg_err(cfg_err), .step_count(step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  kind;
        int unsigned steps;
        int          cyc;
    } res_t;

    int   exp_phase[$];
    res_t exp_res[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [3:0]  lat_row = '0, lat_col = '0;
    int unsigned last_steps = 0;

    always @(posedge clk) cyc++;

    // Monitor
    always @(negedge clk) begin
        logic [4:0] pv;
        logic [7:0] gotv, expv;
        int         s;
        res_t       r;
        if (!rst) begin
            pv = {path_ready, no_path, timeout, aborted, cfg_err};
            if (exp_phase.size() > 0) begin
                s = exp_phase.pop_front();
                expv = {3'(s), s == P_INIT, s == P_UPD, s == P_MOVE, s == P_BT, s != P_IDLE};
                gotv = {state, init_en, update_en, move_en, backtrace_en, busy};
                n_checks++;
                if (gotv !== expv) begin
                    n_fail++;
                    $display("FAIL phase cyc=%0d got {state,en,busy}=%b required=%b", cyc, gotv, expv);
                end
            end
            if (pv != 5'b0) begin
                n_checks++;
                if (exp_res.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d got pulses=%b required=none", cyc, pv);
                end else begin
                    r = exp_res.pop_front();
                    if (pv !== r.kind || step_count !== 16'(r.steps) || cyc != r.cyc) begin
                        n_fail++;
                        $display("FAIL result got pulses=%b steps=%0d cyc=%0d required pulses=%b steps=%0d cyc=%0d",
                                 pv, step_count, cyc, r.kind, r.steps, r.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int st);
        exp_phase.push_back(st);
        @(posedge clk);
        #1;
    endtask

    task automatic push_res(input logic [4:0] kind, input int unsigned steps);
        res_t r;
        r.kind  = kind;
        r.steps = steps;
        r.cyc   = cyc;
        exp_res.push_back(r);
        last_steps = steps;
    endtask

    // Drive strobes a given phase must ignore; the consumed ones stay low.
    task automatic noise(input int st);
        init_done      = (st != P_INIT) ? 1'($urandom % 2) : 1'b0;
        update_done    = (st != P_UPD)  ? 1'($urandom % 2) : 1'b0;
        move_done      = (st != P_MOVE) ? 1'($urandom % 2) : 1'b0;
        backtrace_done = (st != P_BT)   ? 1'($urandom % 2) : 1'b0;
        queue_empty    = (st != P_MOVE) ? 1'($urandom % 2) : 1'b0;
        abort          = (st == P_IDLE) ? 1'($urandom % 2) : 1'b0;
        start          = (st != P_IDLE) ? 1'($urandom % 2) : 1'b0;
        goal_row       = 4'($urandom);
        goal_col       = 4'($urandom);
        pointer_row    = (st == P_MOVE) ? lat_row + 4'd1 : 4'($urandom);
        pointer_col    = 4'($urandom);
    endtask

    task automatic run_search(input int gr, input int gc, input int kind, input int nmoves,
                              input bit ab_en, input int ab_st, input int ab_it);
        int          cur;
        int unsigned steps;
        bit          done;
        noise(P_IDLE);
        start = 1'b1;
        goal_row = 4'(gr);
        goal_col = 4'(gc);
        tick(P_IDLE);
        lat_row = 4'(gr);
        lat_col = 4'(gc);
        cur = P_INIT;
        steps = 0;
        done = 1'b0;
        while (!done) begin
            repeat ($urandom_range(0, 2)) begin
                noise(cur);
                tick(cur);
            end
            noise(cur);
            if (ab_en && cur == ab_st && steps >= ab_it) begin
                abort = 1'b1;
                init_done = 1'b1; update_done = 1'b1; move_done = 1'b1; backtrace_done = 1'b1;
                tick(cur);
                push_res(R_ABT, steps);
                done = 1'b1;
            end else begin
                case (cur)
                    P_INIT: begin init_done = 1'b1; tick(cur); cur = P_UPD; end
                    P_UPD:  begin update_done = 1'b1; tick(cur); cur = P_MOVE; end
                    P_MOVE: begin
                        if (steps == nmoves && kind != K_EMPTY) begin
                            pointer_row = lat_row;
                            pointer_col = lat_col;
                            queue_empty = 1'($urandom % 2);
                            move_done   = 1'($urandom % 2);
                            tick(cur);
                            cur = P_BT;
                        end else if (steps == nmoves) begin
                            queue_empty = 1'b1;
                            move_done   = 1'($urandom % 2);
                            tick(cur);
                            push_res(R_NOP, steps);
                            done = 1'b1;
                        end else begin
                            move_done = 1'b1;
                            tick(cur);
                            steps++;
                            if (steps == MAXS) begin
                                push_res(R_TMO, steps);
                                done = 1'b1;
                            end else begin
                                cur = P_UPD;
                            end
                        end
                    end
                    default: begin
                        if (kind == K_RST) begin
                            #2 rst = 1'b1;
                            #1;
                            n_checks++;
                            if ({state, init_en, update_en, move_en, backtrace_en, busy} !== 8'b0) begin
                                n_fail++;
                                $display("FAIL rst_state got state=%0d busy=%b required state=0 busy=0", state, busy);
                            end
                            n_checks++;
                            if ({step_count, path_ready, no_path, timeout, aborted, cfg_err} !== 21'b0) begin
                                n_fail++;
                                $display("FAIL rst_outputs got steps=%0d pulses=%b required 0/00000", step_count,
                                         {path_ready, no_path, timeout, aborted, cfg_err});
                            end
                            @(posedge clk);
                            #1 rst = 1'b0;
                            last_steps = 0;
                        end else begin
                            backtrace_done = 1'b1;
                            tick(cur);
                            push_res(R_PATH, steps);
                        end
                        done = 1'b1;
                    end
                endcase
            end
        end
    endtask

    task automatic bad_cfg();
        noise(P_IDLE);
        start = 1'b1;
        if ($urandom % 2) begin
            goal_row = 4'($urandom_range(ROWS, 15));
            goal_col = 4'($urandom_range(0, 15));
        end else begin
            goal_row = 4'($urandom_range(0, ROWS - 1));
            goal_col = 4'($urandom_range(COLS, 15));
        end
        tick(P_IDLE);
        push_res(R_CFG, last_steps);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            noise(P_IDLE);
            tick(P_IDLE);
        end
    endtask

    initial begin
        #2;
        n_checks++;
        if ({state, busy, init_en, update_en, move_en, backtrace_en, step_count,
             path_ready, no_path, timeout, aborted, cfg_err} !== 29'b0) begin
            n_fail++;
            $display("FAIL reset_values got state=%0d busy=%b steps=%0d required all zero", state, busy, step_count);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        run_search(0, 9, K_FOUND, 3, 1'b0, 0, 0);
        idle(1);
        run_search(4, 4, K_EMPTY, 2, 1'b0, 0, 0);
        idle(1);
        run_search(2, 7, K_FOUND, 9, 1'b0, 0, 0);
        idle(1);
        noise(P_IDLE);
        start = 1'b1; goal_row = 4'd10; goal_col = 4'd3;
        tick(P_IDLE);
        push_res(R_CFG, last_steps);
        idle(2);
        run_search(5, 1, K_FOUND, 2, 1'b1, P_UPD, 0);
        run_search(9, 0, K_RST, 2, 1'b0, 0, 0);
        idle(2);
        run_search(9, 9, K_FOUND, 0, 1'b0, 0, 0);
        bad_cfg();
        bad_cfg();

        for (int unsigned i = 0; i < 60; i++) begin
            if ($urandom % 6 == 0) begin
                bad_cfg();
            end else begin
                run_search($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
                           int'($urandom % 2), $urandom_range(0, 5),
                           ($urandom % 4) == 0, $urandom_range(1, 4), $urandom_range(0, 3));
            end
            idle($urandom_range(0, 2));
        end

        idle(3);
        n_checks++;
        if (exp_res.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results got %0d outstanding required 0", exp_res.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/astar_seq_ctrl.md
ASTAR_SEQ_CTRL -- requirements
Module: astar_seq_ctrl

Interface
REQ-001 Parameter ROWS, default 10, grid row count, 2..16.
REQ-002 Parameter COLS, default 10, grid column count, 2..16.
REQ-003 Parameter MAX_STEPS, default 255, maximum MOVE->UPDATE iterations per search, 1..65535.
REQ-004 Parameter CW, default 4, coordinate width; SW, default 16, step counter width.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  request new search; sampled only in IDLE.
REQ-008 abort  in  1  cancel active search.
REQ-009 goal_row / goal_col  in  CW  goal cell; latched on accepted start.
REQ-010 pointer_row / pointer_col  in  CW  current expanded cell from datapath.
REQ-011 init_done, update_done, move_done, backtrace_done, queue_empty  in  1  datapath status.
REQ-012 state  out  3  current state encoding.
REQ-013 init_en, update_en, move_en, backtrace_en  out  1  phase enables.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 path_ready, no_path, timeout, aborted, cfg_err  out  1  single-cycle result pulses.
REQ-016 step_count  out  SW  completed MOVE->UPDATE iterations of current/last search.

Function
REQ-017 States: IDLE=0, INIT=1, UPDATE=2, MOVE=3, BACKTRACE=4; codes 5-7 return to IDLE next cycle.
REQ-018 Phase enables are combinational decodes: init_en=INIT, update_en=UPDATE, move_en=MOVE, backtrace_en=BACKTRACE.
REQ-019 IDLE, start=1, goal_row<ROWS and goal_col<COLS: latch goal, clear step_count, go INIT next cycle.
REQ-020 IDLE, start=1 with goal out of range: stay IDLE, pulse cfg_err next cycle, goal register unchanged.
REQ-021 INIT: init_done -> UPDATE.
REQ-022 UPDATE: update_done -> MOVE.
REQ-023 MOVE priority: pointer equals latched goal -> BACKTRACE; else queue_empty -> IDLE with no_path; else move_done -> step check.
REQ-024 Step check: step_count==MAX_STEPS-1 -> IDLE with timeout, step_count becomes MAX_STEPS; else step_count+1, -> UPDATE.
REQ-025 step_count never wraps; holds final value in IDLE until next accepted start.
REQ-026 BACKTRACE: backtrace_done -> IDLE with path_ready.
REQ-027 abort=1 in any non-IDLE state has highest priority: -> IDLE, aborted pulse; abort in IDLE ignored.
REQ-028 Result pulses are registered: high exactly one cycle, the first cycle in IDLE after the causing transition; at most one pulse per search.
REQ-029 start while busy is ignored; start in the same cycle a pulse is high is accepted normally.
REQ-030 Goal comparison uses only latched goal, never live goal inputs.
REQ-031 A status input asserted in a state that does not consume it has no effect.

Reset
REQ-032 rst asserted: state=IDLE, all enables and pulses 0, busy=0, step_count=0, goal register=0, immediately and asynchronously.
REQ-033 rst mid-search abandons the search with no result pulse.

Verification
REQ-034 start, goal=(0,9), init_done, update_done, move_done x3, pointer=(0,9) in MOVE, backtrace_done -> path_ready one cycle, step_count=3.
REQ-035 Search with queue_empty in MOVE at step 2 -> no_path one cycle, state 0, step_count=2.
REQ-036 MAX_STEPS=4, pointer never at goal, done strobes always high -> timeout after 4th move_done, step_count=4.
REQ-037 start, goal=(10,3) with ROWS=10 -> cfg_err one cycle, busy stays 0, state stays 0.
REQ-038 abort during UPDATE with update_done=1 same cycle -> state 0, aborted pulse, no MOVE entered.
REQ-039 rst asserted in BACKTRACE -> state 0 without clock edge, all pulses 0, step_count=0.
